// File: rtl/csa3_seq_adder.sv
// csa3_seq_adder
// Sequential three-operand adder/subtractor. It computes a+b+c or a+b-c over
// WIDTH-bit unsigned operands. One carry-save (3:2) layer reduces the three
// operands to a sum/carry pair. The carry-propagate add then resolves CHUNK
// bits per cycle. The result is RW = WIDTH+2 bits wide.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   rst_n  - asynchronous active-low reset; aborts any operation in flight
//   start  - request; sampled only while idle
//   sub    - 0: a+b+c, 1: a+b-c; captured together with the operands
//   a,b,c  - WIDTH-bit operands, captured on an accepted start
//   s      - RW-bit result; exact sum, or two's-complement difference
//   neg    - subtract mode only: the result is negative
//   busy   - high during the carry-save and carry-propagate phases
//   done   - one-cycle pulse; s/neg are valid from here until the next start
module csa3_seq_adder #(
    parameter int WIDTH = 256,
    parameter int CHUNK = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH+1:0] s,
    output logic             neg,
    output logic             busy,
    output logic             done
);

    localparam int RW  = WIDTH + 2;
    localparam int NCH = (RW + CHUNK - 1) / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, CSA, CPA, DONE} state_t;

    state_t        state, state_next;
    logic [RW-1:0] a_r, b_r, c_r;
    logic          sub_r;
    logic [RW-1:0] ps, pc;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          last_slice;

    logic [RW-1:0] c_eff;
    logic [RW-2:0] maj;
    logic [CHUNK:0] slice_sum;
    logic [31:0]   shamt;
    logic [RW-1:0] slice_mask, slice_val, s_next;

    // Carry-save layer. Subtraction uses ~c here, and its +1 goes into the
    // LSB of the shifted carry vector, which is always free.
    always_comb begin
        c_eff = sub_r ? ~c_r : c_r;
        maj   = (a_r[RW-2:0] & b_r[RW-2:0])
              | (a_r[RW-2:0] & c_eff[RW-2:0])
              | (b_r[RW-2:0] & c_eff[RW-2:0]);
    end

    // One carry-propagate slice. ps/pc shift right as they are consumed, so
    // the low CHUNK bits are always the current slice. The mask shift drops
    // any bits of the final slice that land above RW.
    always_comb begin
        slice_sum  = {1'b0, ps[CHUNK-1:0]} + {1'b0, pc[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry};
        shamt      = 32'(cnt) * 32'(CHUNK);
        slice_mask = RW'({CHUNK{1'b1}}) << shamt;
        slice_val  = RW'(slice_sum[CHUNK-1:0]) << shamt;
        s_next     = (s & ~slice_mask) | slice_val;
        last_slice = (cnt == CW'(NCH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic and the status outputs decoded from the state
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = CSA;
            CSA: begin
                busy       = 1'b1;
                state_next = CPA;
            end
            CPA: begin
                busy = 1'b1;
                if (last_slice) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, carry-save compression, sliced carry-propagate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= '0;
            sub_r <= 1'b0;
            ps    <= '0;
            pc    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= {2'b00, a};
                        b_r   <= {2'b00, b};
                        c_r   <= {2'b00, c};
                        sub_r <= sub;
                    end
                end
                CSA: begin
                    ps    <= a_r ^ b_r ^ c_eff;
                    pc    <= {maj, sub_r};
                    carry <= 1'b0;
                    cnt   <= '0;
                end
                CPA: begin
                    s     <= s_next;
                    carry <= slice_sum[CHUNK];
                    ps    <= ps >> CHUNK;
                    pc    <= pc >> CHUNK;
                    cnt   <= cnt + 1'b1;
                    if (last_slice) neg <= sub_r & s_next[RW-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa3_seq_adder.sv
// tb_csa3_seq_adder
// Bench for csa3_seq_adder. It drives two instances: the default 256/64
// configuration with directed and random operations, and an 8/3
// configuration with 2000 random operations. Expected results are computed
// with plain wide arithmetic and queued when an operation is issued. Each
// instance has a monitor that pops and compares on every done pulse.
module tb_csa3_seq_adder;

    typedef struct {
        logic [257:0] s;
        logic         neg;
        int           start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic         start_b, sub_b;
    logic [255:0] a_b, b_b, c_b;
    logic [257:0] s_b;
    logic         neg_b, busy_b, done_b;

    logic         start_s, sub_s;
    logic [7:0]   a_s, b_s, c_s;
    logic [9:0]   s_s;
    logic         neg_s, busy_s, done_s;

    exp_t q_b[$];
    exp_t q_s[$];
    exp_t eb, es;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    csa3_seq_adder #(.WIDTH(256), .CHUNK(64)) dut_big (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sub(sub_b),
        .a(a_b), .b(b_b), .c(c_b),
        .s(s_b), .neg(neg_b), .busy(busy_b), .done(done_b)
    );

    csa3_seq_adder #(.WIDTH(8), .CHUNK(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .sub(sub_s),
        .a(a_s), .b(b_s), .c(c_s),
        .s(s_s), .neg(neg_s), .busy(busy_s), .done(done_s)
    );

    always #5 clk = ~clk;

    // Count rising edges so the monitors can measure start-to-done latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [257:0] act,
                               input logic [257:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: the exact result modulo 2^(w+2), and a sign bit taken
    // from a true magnitude comparison.
    function automatic exp_t model(input int w, input logic sub,
                                   input logic [257:0] a, input logic [257:0] b,
                                   input logic [257:0] c, input int sc);
        exp_t         e;
        logic [257:0] mask, r;
        mask = (258'(1) << (w + 2)) - 258'(1);
        r    = sub ? (a + b - c) : (a + b + c);
        e.s         = r & mask;
        e.neg       = sub && ((a + b) < c);
        e.start_cyc = sc;
        return e;
    endfunction

    // Issue one operation on the selected instance (0 = big, 1 = small).
    // Call this at a falling edge with the DUT idle. It returns at the
    // falling edge of the first idle cycle after done.
    task automatic applyStimulus(input bit sel, input logic sub,
                                 input logic [255:0] a, input logic [255:0] b,
                                 input logic [255:0] c, input bit repulse);
        int           t;
        logic [257:0] am, bm, cm;
        logic         dn;
        if (sel) begin
            am = {250'b0, a[7:0]};
            bm = {250'b0, b[7:0]};
            cm = {250'b0, c[7:0]};
            a_s = a[7:0]; b_s = b[7:0]; c_s = c[7:0]; sub_s = sub; start_s = 1'b1;
            q_s.push_back(model(8, sub, am, bm, cm, cyc + 1));
        end else begin
            am = {2'b00, a};
            bm = {2'b00, b};
            cm = {2'b00, c};
            a_b = a; b_b = b; c_b = c; sub_b = sub; start_b = 1'b1;
            q_b.push_back(model(256, sub, am, bm, cm, cyc + 1));
        end
        @(negedge clk);
        start_b = 1'b0;
        start_s = 1'b0;
        checkOutput(sel ? "small_busy_after_start" : "big_busy_after_start",
                    258'(sel ? busy_s : busy_b), 258'(1));
        // Scramble the inputs; the running operation must not see them
        a_b = rnd256(); b_b = rnd256(); c_b = rnd256(); sub_b = $urandom_range(0, 1) == 1;
        a_s = 8'($urandom()); b_s = 8'($urandom()); c_s = 8'($urandom()); sub_s = ~sub_s;
        @(negedge clk);
        @(negedge clk);
        if (repulse) begin
            if (sel) start_s = 1'b1;
            else     start_b = 1'b1;
        end
        @(negedge clk);
        start_b = 1'b0;
        start_s = 1'b0;
        t  = 0;
        dn = sel ? done_s : done_b;
        while (!dn && t < 40) begin
            @(negedge clk);
            t++;
            dn = sel ? done_s : done_b;
        end
        if (!dn) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s_done_timeout: got no done expected done within 40 cycles",
                     sel ? "small" : "big");
        end
        @(negedge clk);
    endtask

    // Start an operation, then assert reset while it is in the carry-propagate
    // phase. It must leave the block idle with s cleared and never pulse done.
    task automatic abortRun();
        a_b = rnd256() | 256'hFF; b_b = rnd256(); c_b = rnd256(); sub_b = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 258'(busy_b), 258'(0));
        checkOutput("abort_s", s_b, 258'(0));
        checkOutput("abort_done", 258'(done_b), 258'(0));
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Monitor for the 256-bit instance
    always @(negedge clk) begin
        if (rst_n && done_b) begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL big_unexpected_done: got done expected none");
            end else begin
                eb = q_b.pop_front();
                checkOutput("big_s", s_b, eb.s);
                checkOutput("big_neg", 258'(neg_b), 258'(eb.neg));
                checkOutput("big_latency", 258'(cyc - eb.start_cyc), 258'(6));
                checkOutput("big_busy_at_done", 258'(busy_b), 258'(0));
            end
        end
    end

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (rst_n && done_s) begin
            if (q_s.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL small_unexpected_done: got done expected none");
            end else begin
                es = q_s.pop_front();
                checkOutput("small_s", 258'(s_s), es.s);
                checkOutput("small_neg", 258'(neg_s), 258'(es.neg));
                checkOutput("small_latency", 258'(cyc - es.start_cyc), 258'(5));
            end
        end
    end

    initial begin
        logic [255:0] ones;
        ones  = '1;
        rst_n = 1'b0;
        start_b = 1'b0; sub_b = 1'b0; a_b = '0; b_b = '0; c_b = '0;
        start_s = 1'b0; sub_s = 1'b0; a_s = '0; b_s = '0; c_s = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_s", s_b, 258'(0));
        checkOutput("reset_busy", 258'(busy_b), 258'(0));
        checkOutput("reset_done", 258'(done_b), 258'(0));
        checkOutput("reset_neg", 258'(neg_b), 258'(0));
        checkOutput("reset_small_s", 258'(s_s), 258'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, issued back to back
        applyStimulus(0, 1'b0, 256'd125, 256'd421, 256'd15, 1'b0);
        applyStimulus(0, 1'b0, ones, 256'd2, 256'd3, 1'b0);
        applyStimulus(0, 1'b0, ones, ones, ones, 1'b0);
        applyStimulus(0, 1'b1, 256'd3125, 256'd1421, 256'd155, 1'b0);
        applyStimulus(0, 1'b1, 256'd100, 256'd50, 256'd200, 1'b0);
        applyStimulus(0, 1'b1, 256'd0, 256'd0, 256'd0, 1'b0);
        applyStimulus(0, 1'b1, 256'd0, 256'd0, ones, 1'b0);
        // start re-pulsed mid-operation must be ignored
        applyStimulus(0, 1'b0, 256'd7, 256'd9, 256'd11, 1'b1);
        abortRun();
        applyStimulus(0, 1'b0, 256'd1, 256'd2, 256'd3, 1'b0);

        for (int i = 0; i < 20; i++)
            applyStimulus(0, 1'($urandom_range(0, 1)), rnd256(), rnd256(), rnd256(),
                          $urandom_range(0, 4) == 0);

        for (int i = 0; i < 2000; i++)
            applyStimulus(1, 1'($urandom_range(0, 1)), 256'($urandom()),
                          256'($urandom()), 256'($urandom()),
                          $urandom_range(0, 9) == 0);

        repeat (10) @(negedge clk);
        checkOutput("big_queue_drained", 258'(q_b.size()), 258'(0));
        checkOutput("small_queue_drained", 258'(q_s.size()), 258'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
